// File: rtl/mse_batch_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mse_batch_engine: per-channel sum-of-squared-error over a programmable batch |
// | Optional: MSE_BATCH_MAXERR_EN adds res_maxerr (peak |diff| per channel)      |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module mse_batch_engine #(
  parameter int NUM_DUT = 2,
  parameter int DATA_WL = 16,
  parameter int ACC_WL  = 64,
  parameter int CNT_WL  = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [CNT_WL-1:0]                                 num_samples,
  input  logic [CNT_WL-1:0]                                 warmup,
  input  logic                                              in_valid,
  input  logic [NUM_DUT*DATA_WL-1:0]                        data_in,
  input  logic [DATA_WL-1:0]                                data_ref,
  output logic                                              busy,
  output logic                                              res_valid,
  input  logic                                              res_ready,
  output logic [(NUM_DUT > 1 ? $clog2(NUM_DUT) : 1)-1:0]    res_idx,
  output logic [ACC_WL-1:0]                                 res_data,
`ifdef MSE_BATCH_MAXERR_EN
  output logic [DATA_WL:0]                                  res_maxerr,
`endif
  output logic                                              done
);

  localparam int IDX_WL = (NUM_DUT > 1) ? $clog2(NUM_DUT) : 1;
  localparam int SQ_WL  = 2 * DATA_WL + 2;
  localparam int SUM_WL = ((ACC_WL > SQ_WL) ? ACC_WL : SQ_WL) + 1;
  localparam logic [IDX_WL-1:0] LAST_IDX = IDX_WL'(NUM_DUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_ACCUM  = 3'd2,
    S_FLUSH  = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_WL-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_WL-1:0]   nsamp_q, nsamp_d;
  logic [CNT_WL-1:0]   warm_q, warm_d;
  logic [1:0]          flush_q, flush_d;
  logic [IDX_WL-1:0]   idx_q, idx_d;
  logic                done_q, done_d;
  logic                v1_q, v2_q;
  logic                accept, clear;
  logic [ACC_WL-1:0]   acc_all [NUM_DUT];

  assign cnt_inc = cnt_q + CNT_WL'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nsamp_q <= '0;
      warm_q  <= '0;
      flush_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nsamp_q <= nsamp_d;
      warm_q  <= warm_d;
      flush_q <= flush_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsamp_d = nsamp_q;
    warm_d  = warm_q;
    flush_d = flush_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nsamp_d = num_samples;
          warm_d  = warmup;
          cnt_d   = '0;
          clear   = 1'b1;
          state_d = (warmup != '0) ? S_WARMUP : S_ACCUM;
        end
      end
      S_WARMUP: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == warm_q) begin
            cnt_d   = '0;
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        // A zero-length batch leaves without accepting anything.
        if (cnt_q == nsamp_q) begin
          state_d = S_FLUSH;
        end else if (in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == nsamp_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_q == 2'd2) begin
          flush_d = '0;
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          flush_d = flush_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_WL'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MSE_BATCH_MAXERR_EN
  logic [DATA_WL:0] maxerr_all [NUM_DUT];
`endif

  for (genvar k = 0; k < NUM_DUT; k++) begin : g_ch
    logic signed [DATA_WL:0] diff_q;
    logic [SQ_WL-1:0]        sq_q;
    logic [ACC_WL-1:0]       acc_q;
    logic signed [DATA_WL:0] diff_w;
    logic signed [SQ_WL-1:0] prod_w;
    logic [SUM_WL-1:0]       sum_w;

    assign diff_w = $signed({data_in[k*DATA_WL+DATA_WL-1], data_in[k*DATA_WL +: DATA_WL]})
                  - $signed({data_ref[DATA_WL-1], data_ref});
    assign prod_w = diff_q * diff_q;
    // Sum is one bit wider than either operand so overflow shows up above ACC_WL.
    assign sum_w  = SUM_WL'(acc_q) + SUM_WL'(sq_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        diff_q <= '0;
        sq_q   <= '0;
        acc_q  <= '0;
      end else begin
        if (accept) diff_q <= diff_w;
        if (v1_q)   sq_q   <= $unsigned(prod_w);
        if (clear) begin
          acc_q <= '0;
        end else if (v2_q) begin
          acc_q <= (|(sum_w >> ACC_WL)) ? {ACC_WL{1'b1}} : sum_w[ACC_WL-1:0];
        end
      end
    end

    assign acc_all[k] = acc_q;

`ifdef MSE_BATCH_MAXERR_EN
    logic [DATA_WL:0] maxerr_q;
    logic [DATA_WL:0] abs_w;

    assign abs_w = diff_q[DATA_WL] ? $unsigned(-diff_q) : $unsigned(diff_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        maxerr_q <= '0;
      end else if (clear) begin
        maxerr_q <= '0;
      end else if (v1_q && (abs_w > maxerr_q)) begin
        maxerr_q <= abs_w;
      end
    end

    assign maxerr_all[k] = maxerr_q;
`endif
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DRAIN);
  assign res_idx   = idx_q;
  assign res_data  = res_valid ? acc_all[idx_q] : '0;
  assign done      = done_q;
`ifdef MSE_BATCH_MAXERR_EN
  assign res_maxerr = res_valid ? maxerr_all[idx_q] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mse_batch_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mse_batch_engine: directed self-checking bench for mse_batch_engine       |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_mse_batch_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_samples;
  logic [31:0] warmup;
  logic        in_valid;
  logic [31:0] data_in;
  logic [15:0] data_ref;
  logic        res_ready;

  logic        busy, res_valid, done;
  logic [0:0]  res_idx;
  logic [63:0] res_data;
  logic        sat_busy, sat_res_valid, sat_done;
  logic [0:0]  sat_res_idx;
  logic [7:0]  sat_res_data;
`ifdef MSE_BATCH_MAXERR_EN
  logic [16:0] res_maxerr, sat_res_maxerr;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat;

  mse_batch_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .warmup(warmup),
    .in_valid(in_valid), .data_in(data_in), .data_ref(data_ref), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
`ifdef MSE_BATCH_MAXERR_EN
    .res_maxerr(res_maxerr),
`endif
    .done(done)
  );

  mse_batch_engine #(.ACC_WL(8)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .warmup(warmup),
    .in_valid(in_valid), .data_in(data_in), .data_ref(data_ref), .busy(sat_busy),
    .res_valid(sat_res_valid), .res_ready(res_ready), .res_idx(sat_res_idx),
    .res_data(sat_res_data),
`ifdef MSE_BATCH_MAXERR_EN
    .res_maxerr(sat_res_maxerr),
`endif
    .done(sat_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick(input int w, input int n);
    start = 1'b1; warmup = w; num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // diffs are relative to a fixed reference of 100
  task automatic drive(input logic v, input int d0, input int d1);
    in_valid = v;
    data_in  = {16'(100 + d1), 16'(100 + d0)};
    data_ref = 16'd100;
    @(negedge clk);
  endtask

  task automatic wait_res(output int cyc);
    in_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("res_valid_arrives", res_valid, 1);
  endtask

  task automatic take(input int idx, input logic [63:0] exp);
    chk("res_valid", res_valid, 1);
    chk("res_idx", res_idx, idx);
    chk("res_data", res_data, exp);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic finish_chk();
    chk("done", done, 1);
    chk("busy_idle", busy, 0);
    chk("res_valid_idle", res_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0; warmup = '0;
    in_valid = 1'b0; data_in = '0; data_ref = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic: ch0 1+4+9+0, ch1 4*25
    kick(0, 4);
    chk("busy_accum", busy, 1);
    drive(1, 1, 5); drive(1, -2, 5); drive(1, 3, 5); drive(1, 0, 5);
    wait_res(lat);
    chk("latency", lat, 3);
    take(0, 14);
    take(1, 100);
    finish_chk();

    // warm-up: 3 discarded samples, then 2 with diff 1 / -1
    kick(3, 2);
    drive(1, 100, 100); drive(1, 100, 100); drive(1, 100, 100);
    drive(1, 1, -1); drive(1, 1, -1);
    wait_res(lat);
    take(0, 2);
    take(1, 2);
    finish_chk();

    // in_valid gaps and backpressure
    kick(0, 3);
    drive(1, 1, 1); drive(0, 9, 9); drive(1, 1, 1); drive(0, 9, 9); drive(1, 1, 1);
    wait_res(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_idx_hold", res_idx, 0);
      chk("bp_data_hold", res_data, 3);
      @(negedge clk);
    end
    take(0, 3);
    take(1, 3);
    finish_chk();

    // saturation on the 8-bit accumulator instance
    kick(0, 2);
    drive(1, 16, 16); drive(1, 16, 16);
    wait_res(lat);
    chk("sat_valid", sat_res_valid, 1);
    chk("sat_busy", sat_busy, 1);
    chk("sat_idx0", sat_res_idx, 0);
    chk("sat_data0", sat_res_data, 255);
    take(0, 512);
    chk("sat_idx1", sat_res_idx, 1);
    chk("sat_data1", sat_res_data, 255);
    take(1, 512);
    chk("sat_done", sat_done, 1);
    finish_chk();

    // zero-length batch
    kick(0, 0);
    wait_res(lat);
    take(0, 0);
    take(1, 0);
    finish_chk();

    // start during ACCUM is ignored
    kick(0, 2);
    drive(1, 2, 0);
    start = 1'b1; num_samples = 10;
    drive(1, 3, 1);
    start = 1'b0;
    wait_res(lat);
    chk("latency_ign_start", lat, 3);
    take(0, 13);
    take(1, 1);
    finish_chk();

    // asynchronous reset mid-ACCUM, then a clean batch
    kick(0, 4);
    drive(1, 4, 4); drive(1, 4, 4);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_busy_next", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    kick(0, 1);
    drive(1, 7, -3);
    wait_res(lat);
    take(0, 49);
    take(1, 9);
    finish_chk();

    // extreme operands: -32768 vs 32767 on ch0, 0 vs 32767 on ch1
    kick(0, 1);
    in_valid = 1'b1; data_in = {16'h0000, 16'h8000}; data_ref = 16'h7FFF;
    @(negedge clk);
    wait_res(lat);
`ifdef MSE_BATCH_MAXERR_EN
    chk("maxerr0", res_maxerr, 65535);
`endif
    take(0, 64'd4294836225);
`ifdef MSE_BATCH_MAXERR_EN
    chk("maxerr1", res_maxerr, 32767);
`endif
    take(1, 64'd1073676289);
    finish_chk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
